// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory request/response channel,
// the redirect port and the decode valid/ready channel of fetch_queue.
//   master : the fetch queue itself (drives imem_req/imem_addr and the
//            instruction outputs, receives grant/response/redirect/ready)
//   slave  : the surrounding environment (memory + decode + branch unit)
interface fetch_queue_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction_code;
  logic [63:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction_code, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction_code, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction prefetcher. Issues 32-bit reads at a
// 64-bit PC, buffers returned words with their PC in a DEPTH-entry FIFO and
// presents the head to decode over valid/ready. A redirect flushes the FIFO,
// marks in-flight responses for discard and restarts fetch at a new PC.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous active-low reset
//   bus    : fetch_queue_if.master (imem request/response, redirect, decode)
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   pc_mem_q   [DEPTH];
  logic [31:0]   word_mem_q [DEPTH];

  logic [CW:0] in_use;
  logic        req;
  logic        grant;
  logic        rsp;
  logic        discard;
  logic        push;
  logic        pop;

  // Credit: FIFO entries plus in-flight requests never exceed DEPTH, so every
  // response that is kept is guaranteed a free slot.
  assign in_use  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req     = reset & ~bus.redirect & (in_use < DEPTH_W);
  assign grant   = req & bus.imem_gnt;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp     = bus.imem_rvalid & (outstanding_q != '0);
  assign discard = (drop_q != '0);
  assign push    = rsp & ~discard & ~bus.redirect;
  assign pop     = (count_q != '0) & bus.instr_ready & ~bus.redirect;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (bus.redirect) begin
      fetch_pc_d    = {bus.redirect_pc[63:2], 2'b00};
      resp_pc_d     = {bus.redirect_pc[63:2], 2'b00};
      // Everything still in flight after this cycle is stale.
      outstanding_d = outstanding_q - CW'(rsp);
      drop_d        = outstanding_q - CW'(rsp);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 64'd4;
      end
      outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
      drop_d        = drop_q - CW'(rsp & discard);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 64'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pc_mem_q      <= '{default: '0};
      word_mem_q    <= '{default: '0};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        word_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req         = req;
  assign bus.imem_addr        = fetch_pc_q;
  assign bus.instr_valid      = (count_q != '0);
  assign bus.instruction_code = word_mem_q[rd_ptr_q];
  assign bus.instr_pc         = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3 ^ (a[63:32] << 4);
  endfunction

  // ---------------- memory responder ----------------
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  int          mem_lat   = 1;
  bit          stray     = 0;
  int          grant_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (bus.imem_req && bus.imem_gnt) begin
      pend_addr.push_back(bus.imem_addr);
      pend_due.push_back(cyc + mem_lat);
      grant_cnt++;
    end
  end

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = word_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else if (stray) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        stray           = 0;
      end else begin
        bus.imem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [95:0] mq[$];          // {pc, word} waiting for decode
  logic [63:0] m_fetch, m_resp;
  int          m_out, m_drop;
  bit          m_live = 0;

  function automatic bit m_req();
    return rst_n && !bus.redirect && (mq.size() + m_out < DEPTH);
  endfunction

  task automatic model_step();
    bit g, r;
    if (!rst_n) begin
      m_fetch = RESET_PC;
      m_resp  = RESET_PC;
      m_out   = 0;
      m_drop  = 0;
      mq.delete();
      m_live  = 1;
    end else if (m_live) begin
      r = bus.imem_rvalid && (m_out > 0);
      if (bus.redirect) begin
        m_drop  = m_out - (r ? 1 : 0);
        m_out   = m_drop;
        mq.delete();
        m_fetch = {bus.redirect_pc[63:2], 2'b00};
        m_resp  = m_fetch;
      end else begin
        g = m_req() && bus.imem_gnt;
        if (mq.size() > 0 && bus.instr_ready) void'(mq.pop_front());
        if (r) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back({m_resp, bus.imem_rdata});
            m_resp = m_resp + 64'd4;
          end
        end
        if (g) begin
          m_fetch = m_fetch + 64'd4;
          m_out++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("imem_req", 64'(bus.imem_req), 64'(m_req()));
      chk("imem_addr", bus.imem_addr, m_fetch);
      chk("instr_valid", 64'(bus.instr_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("instr_pc", bus.instr_pc, mq[0][95:32]);
        chk("instruction_code", 64'(bus.instruction_code), 64'(mq[0][31:0]));
        chk("code_vs_pc", 64'(bus.instruction_code), 64'(word_of(mq[0][95:32])));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    bus.imem_gnt    = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst_n           = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_req", 64'(bus.imem_req), 64'h0);
    chk("rst_addr", bus.imem_addr, RESET_PC);
    chk("rst_valid", 64'(bus.instr_valid), 64'h0);
    chk("rst_code", 64'(bus.instruction_code), 64'h0);
    chk("rst_pc", bus.instr_pc, 64'h0);

    // Streaming: gnt=1, 1-cycle latency, ready=1.
    rst_n = 1'b1;
    #1;
    chk("first_req", 64'(bus.imem_req), 64'h1);
    chk("first_addr", bus.imem_addr, 64'h0);
    tick();
    chk("second_addr", bus.imem_addr, 64'h4);
    chk("c1_valid", 64'(bus.instr_valid), 64'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("stream_valid", 64'(bus.instr_valid), 64'h1);
      chk("stream_pc", bus.instr_pc, 64'(4 * k));
      tick();
    end

    // Full with ready=0.
    bus.instr_ready = 1'b0;
    do_reset();
    grant_cnt = 0;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("full_grants", 64'(grant_cnt), 64'd4);
    chk("full_req", 64'(bus.imem_req), 64'h0);
    chk("full_head", bus.instr_pc, 64'h0);
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", bus.instr_pc, 64'(4 * k));
      tick();
    end

    // Redirect with 3 outstanding (4-cycle memory latency).
    mem_lat = 4;
    do_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h1003;
    #1;
    chk("redir_req_low", 64'(bus.imem_req), 64'h0);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("redir_addr", bus.imem_addr, 64'h1000);
    chk("redir_req", 64'(bus.imem_req), 64'h1);
    n = 0;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk("redir_wait_bound", 64'(n < 20), 64'h1);
    chk("redir_latency", 64'(n), 64'd5);
    chk("redir_first_pc", bus.instr_pc, 64'h1000);

    // Redirect together with rvalid and ready, count=2.
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    do_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h2000;
    #1;
    chk("pre_redir_valid", 64'(bus.instr_valid), 64'h1);
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("post_redir_empty", 64'(bus.instr_valid), 64'h0);
    chk("post_redir_addr", bus.imem_addr, 64'h2000);
    tick();
    chk("r2_valid", 64'(bus.instr_valid), 64'h0);
    tick();
    chk("r3_valid", 64'(bus.instr_valid), 64'h1);
    chk("r3_pc", bus.instr_pc, 64'h2000);

    // Address wrap at 2^64.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    bus.redirect = 1'b0;
    #1;
    chk("wrap_addr0", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_addr1", bus.imem_addr, 64'h0);
    tick();
    chk("wrap_pc0", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_pc1", bus.instr_pc, 64'h0);

    // Mid-stream reset with count=3, outstanding=1, then a stray response.
    bus.instr_ready = 1'b0;
    do_reset();
    rst_n = 1'b1;
    repeat (4) tick();
    rst_n        = 1'b0;
    bus.imem_gnt = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.instr_valid), 64'h0);
    chk("mid_rst_addr", bus.imem_addr, RESET_PC);
    chk("mid_rst_req", 64'(bus.imem_req), 64'h1);
    stray = 1;
    repeat (3) tick();
    chk("stray_ignored", 64'(bus.instr_valid), 64'h0);
    chk("stray_addr", bus.imem_addr, RESET_PC);
    bus.imem_gnt    = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
